// File: rtl/packet_history_extract.sv
// packet_history_extract: receive end of the packet-history stream.
// Each packet carries two 512-bit history header beats ahead of the original
// frame. The headers are stripped, the frame is forwarded through a single
// register stage, and the eight carried tuples are drained oldest first on
// a separate tuple interface while the payload flows.

module packet_history_extract #(
    parameter int C_M_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int TUPLE_WIDTH          = 112,
    parameter int HIST_ENTRIES         = 8,
    parameter int PTR_WIDTH            = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [TUPLE_WIDTH-1:0]            hist_tuple,
    output logic [$clog2(HIST_ENTRIES)-1:0]   hist_index,
    output logic                              hist_valid,
    input  logic                              hist_ready,
    output logic                              hist_last,
    output logic [15:0]                       err_count
);

    localparam int IDX_W         = $clog2(HIST_ENTRIES);
    localparam int ISSUE_W       = IDX_W + 1;
    localparam int TPB           = HIST_ENTRIES / 2;   // tuples per header beat
    localparam int HDR_TUPLE_LSB = 16;
    // Only the low IDX_W bits of the pointer field select an entry.
    localparam int PTR_LSBS      = (PTR_WIDTH > IDX_W) ? IDX_W : PTR_WIDTH;

    localparam logic [1:0] ST_HDR0    = 2'd0;
    localparam logic [1:0] ST_HDR1    = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    logic [1:0]                       state_q, state_d;
    logic [IDX_W-1:0]                 ptr_q, ptr_d;
    logic [TUPLE_WIDTH-1:0]           mem_q [HIST_ENTRIES];
    logic [TUPLE_WIDTH-1:0]           mem_d [HIST_ENTRIES];
    logic                             drain_busy_q, drain_busy_d;
    logic [ISSUE_W-1:0]               issue_k_q, issue_k_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_keep_q, m_keep_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]  m_user_q, m_user_d;
    logic                             m_last_q, m_last_d;
    logic                             m_valid_q, m_valid_d;
    logic [TUPLE_WIDTH-1:0]           h_tuple_q, h_tuple_d;
    logic [IDX_W-1:0]                 h_index_q, h_index_d;
    logic                             h_valid_q, h_valid_d;
    logic                             h_last_q, h_last_d;
    logic [15:0]                      err_q, err_d;

    logic                             s_ready_s;
    logic                             s_hs_s;
    logic                             issue_done_s;
    logic [IDX_W-1:0]                 rd_idx_s;

    // Input acceptance: headers wait for a finished drain, payload follows the output register.
    always_comb begin
        case (state_q)
            ST_HDR0:    s_ready_s = !drain_busy_q;
            ST_HDR1:    s_ready_s = 1'b1;
            ST_PAYLOAD: s_ready_s = !m_valid_q || m_axis_tready;
            default:    s_ready_s = 1'b0;
        endcase
    end

    assign s_hs_s       = s_axis_tvalid && s_ready_s;
    assign issue_done_s = (issue_k_q == ISSUE_W'(HIST_ENTRIES));
    assign rd_idx_s     = ptr_q + issue_k_q[IDX_W-1:0];

    // Next-state logic for the header FSM, output register, drain and error counter.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        mem_d        = mem_q;
        drain_busy_d = drain_busy_q;
        issue_k_d    = issue_k_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_user_d     = m_user_q;
        m_last_d     = m_last_q;
        m_valid_d    = m_valid_q;
        h_tuple_d    = h_tuple_q;
        h_index_d    = h_index_q;
        h_valid_d    = h_valid_q;
        h_last_d     = h_last_q;
        err_d        = err_q;

        case (state_q)
            ST_HDR0: begin
                if (s_hs_s) begin
                    ptr_d = IDX_W'(s_axis_tdata[PTR_LSBS-1:0]);
                    for (int k = 0; k < TPB; k++) begin
                        mem_d[k] = s_axis_tdata[HDR_TUPLE_LSB + TUPLE_WIDTH*k +: TUPLE_WIDTH];
                    end
                    if (s_axis_tlast) begin
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end else begin
                            err_d = err_q;
                        end
                    end else begin
                        state_d = ST_HDR1;
                    end
                end else begin
                    state_d = ST_HDR0;
                end
            end
            ST_HDR1: begin
                if (s_hs_s) begin
                    for (int k = 0; k < TPB; k++) begin
                        mem_d[TPB + k] = s_axis_tdata[HDR_TUPLE_LSB + TUPLE_WIDTH*k +: TUPLE_WIDTH];
                    end
                    if (s_axis_tlast) begin
                        // Empty frame: header is useless, so no drain is started.
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end else begin
                            err_d = err_q;
                        end
                        state_d = ST_HDR0;
                    end else begin
                        drain_busy_d = 1'b1;
                        issue_k_d    = {ISSUE_W{1'b0}};
                        state_d      = ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_HDR1;
                end
            end
            ST_PAYLOAD: begin
                if (s_hs_s && s_axis_tlast) begin
                    state_d = ST_HDR0;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            default: begin
                state_d = ST_HDR0;
            end
        endcase

        // Single register stage on the frame path; data is left untouched once drained.
        if (s_hs_s && (state_q == ST_PAYLOAD)) begin
            m_data_d  = s_axis_tdata;
            m_keep_d  = s_axis_tkeep;
            m_user_d  = s_axis_tuser;
            m_last_d  = s_axis_tlast;
            m_valid_d = 1'b1;
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end

        // Drain: refill the tuple register whenever it is empty or being accepted.
        if (drain_busy_q && !issue_done_s && (!h_valid_q || hist_ready)) begin
            h_tuple_d = mem_q[rd_idx_s];
            h_index_d = issue_k_q[IDX_W-1:0];
            h_last_d  = (issue_k_q == ISSUE_W'(HIST_ENTRIES - 1));
            h_valid_d = 1'b1;
            issue_k_d = issue_k_q + ISSUE_W'(1);
        end else if (h_valid_q && hist_ready) begin
            h_valid_d = 1'b0;
            if (h_last_q) begin
                drain_busy_d = 1'b0;
            end else begin
                drain_busy_d = drain_busy_q;
            end
        end else begin
            h_valid_d = h_valid_q;
        end
    end

    // State registers with synchronous active-high reset that aborts any packet or drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HDR0;
            ptr_q        <= {IDX_W{1'b0}};
            for (int i = 0; i < HIST_ENTRIES; i++) begin
                mem_q[i] <= {TUPLE_WIDTH{1'b0}};
            end
            drain_busy_q <= 1'b0;
            issue_k_q    <= {ISSUE_W{1'b0}};
            m_data_q     <= {C_M_AXIS_DATA_WIDTH{1'b0}};
            m_keep_q     <= {(C_M_AXIS_DATA_WIDTH/8){1'b0}};
            m_user_q     <= {C_M_AXIS_TUSER_WIDTH{1'b0}};
            m_last_q     <= 1'b0;
            m_valid_q    <= 1'b0;
            h_tuple_q    <= {TUPLE_WIDTH{1'b0}};
            h_index_q    <= {IDX_W{1'b0}};
            h_valid_q    <= 1'b0;
            h_last_q     <= 1'b0;
            err_q        <= 16'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            mem_q        <= mem_d;
            drain_busy_q <= drain_busy_d;
            issue_k_q    <= issue_k_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_user_q     <= m_user_d;
            m_last_q     <= m_last_d;
            m_valid_q    <= m_valid_d;
            h_tuple_q    <= h_tuple_d;
            h_index_q    <= h_index_d;
            h_valid_q    <= h_valid_d;
            h_last_q     <= h_last_d;
            err_q        <= err_d;
        end
    end

    assign s_axis_tready = s_ready_s;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tvalid = m_valid_q;
    assign hist_tuple    = h_tuple_q;
    assign hist_index    = h_index_q;
    assign hist_valid    = h_valid_q;
    assign hist_last     = h_last_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_packet_history_extract.sv
// Directed bench for packet_history_extract with a queue-based reference model.
module tb_packet_history_extract;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [111:0] hist_tuple;
    logic [2:0]   hist_index;
    logic         hist_valid;
    logic         hist_ready;
    logic         hist_last;
    logic [15:0]  err_count;

    packet_history_extract dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .hist_tuple(hist_tuple), .hist_index(hist_index), .hist_valid(hist_valid),
        .hist_ready(hist_ready), .hist_last(hist_last), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic [127:0] u;
        logic         l;
    } m_item_t;

    typedef struct {
        logic [111:0] t;
        logic [2:0]   idx;
        logic         l;
    } h_item_t;

    m_item_t exp_m[$];
    h_item_t exp_h[$];
    int      err_exp = 0;
    int      n_cmp = 0;
    int      n_fail = 0;
    int      cyc = 0;
    int      hist_ready_at = 0;
    bit      tog_en = 1'b0;
    int      last_hist_cyc = -1;
    logic [15:0] hist_log [0:63];
    int      hist_log_n = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [111:0] mk_tuple(input int pkt, input int j);
        logic [15:0] tag;
        tag = 16'hA0 + 16'(j);
        return {tag, 8'(pkt), {11{8'(j + 16 * pkt)}}};
    endfunction

    function automatic logic [511:0] beat_data(input int pkt, input int i);
        return {16{32'(pkt * 256 + i)}} ^ {8{64'h0123_4567_89AB_CDEF}};
    endfunction

    function automatic logic [63:0] beat_keep(input int i, input int n);
        return (i == n - 1) ? 64'h0000_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [127:0] beat_user(input int pkt, input int i);
        return {4{32'(pkt * 16 + i + 7)}};
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Output-ready stimulus: optional toggling pattern.
    always @(posedge clk) begin
        #1;
        if (tog_en) m_axis_tready = !m_axis_tready;
    end

    // Tuple consumer becomes ready from a chosen cycle on.
    always @(posedge clk) begin
        #1;
        hist_ready = (cyc >= hist_ready_at);
    end

    // Compare process: checks every handshake and every stalled cycle against the model.
    logic         m_stall_prev = 1'b0;
    logic [511:0] m_prev_d;
    logic [192:0] m_prev_side;
    logic         h_stall_prev = 1'b0;
    logic [115:0] h_prev;
    always @(negedge clk) begin
        if (reset) begin
            m_stall_prev = 1'b0;
            h_stall_prev = 1'b0;
        end else begin
            if (m_stall_prev) begin
                chk("m_hold_valid", 512'(m_axis_tvalid), 512'(1));
                chk("m_hold_data", m_axis_tdata, m_prev_d);
                chk("m_hold_side", 512'({m_axis_tkeep, m_axis_tuser, m_axis_tlast}), 512'(m_prev_side));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_m.size() == 0) begin
                    chk("m_unexpected_beat", 512'(1), 512'(0));
                end else begin
                    m_item_t e;
                    e = exp_m.pop_front();
                    chk("m_data", m_axis_tdata, e.d);
                    chk("m_keep_user_last", 512'({m_axis_tkeep, m_axis_tuser, m_axis_tlast}),
                        512'({e.k, e.u, e.l}));
                end
            end
            m_stall_prev = m_axis_tvalid && !m_axis_tready;
            m_prev_d     = m_axis_tdata;
            m_prev_side  = {m_axis_tkeep, m_axis_tuser, m_axis_tlast};

            if (h_stall_prev) begin
                chk("h_hold", 512'({hist_valid, hist_tuple, hist_index}), 512'(h_prev));
            end
            if (hist_valid && hist_ready) begin
                if (exp_h.size() == 0) begin
                    chk("h_unexpected_tuple", 512'(1), 512'(0));
                end else begin
                    h_item_t e;
                    e = exp_h.pop_front();
                    chk("h_tuple_index_last", 512'({hist_tuple, hist_index, hist_last}),
                        512'({e.t, e.idx, e.l}));
                end
                if (hist_log_n < 64) begin
                    hist_log[hist_log_n] = hist_tuple[111:96];
                    hist_log_n++;
                end
                if (hist_last) last_hist_cyc = cyc;
            end
            h_stall_prev = hist_valid && !hist_ready;
            h_prev       = {1'b1, hist_tuple, hist_index};

            chk("err_count", 512'(err_count), 512'(err_exp));
        end
    end

    // Present one beat and wait (bounded) for its handshake; returns the accept cycle.
    task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic [127:0] u,
                             input logic l, output int acc);
        acc = -1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("s_handshake_timeout", 512'(0), 512'(1));
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    // Send a whole packet (headers + nbeats payload) and update the model.
    task automatic send_pkt(input int pkt, input logic [3:0] ptr, input int nbeats,
                            input bit chk_lat, output int acc0);
        logic [111:0] t [8];
        logic [511:0] h0, h1;
        int           acc;
        for (int j = 0; j < 8; j++) t[j] = mk_tuple(pkt, j);
        h0 = {48'hFACE_0000_BEEF, t[3], t[2], t[1], t[0], 12'h5A5, ptr};
        h1 = {48'hCAFE_1111_D00D, t[7], t[6], t[5], t[4], 16'hC3C3};
        send_beat(h0, 64'h1, 128'hDEAD, 1'b0, acc0);
        send_beat(h1, 64'h3, 128'hBEEF, (nbeats == 0), acc);
        if (nbeats == 0) begin
            err_exp++;
        end else begin
            for (int k = 0; k < 8; k++) begin
                h_item_t e;
                e.t   = t[(int'(ptr) + k) % 8];
                e.idx = 3'(k);
                e.l   = (k == 7);
                exp_h.push_back(e);
            end
            for (int i = 0; i < nbeats; i++) begin
                m_item_t e;
                e.d = beat_data(pkt, i);
                e.k = beat_keep(i, nbeats);
                e.u = beat_user(pkt, i);
                e.l = (i == nbeats - 1);
                send_beat(e.d, e.k, e.u, e.l, acc);
                exp_m.push_back(e);
                if (chk_lat && i == 0) begin
                    chk("first_beat_latency_valid", 512'(m_axis_tvalid), 512'(1));
                    chk("first_beat_latency_data", m_axis_tdata, e.d);
                end
            end
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (exp_m.size() == 0 && exp_h.size() == 0 && !m_axis_tvalid && !hist_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("idle_timeout", 512'(0), 512'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0, acc;
        logic [111:0] t [8];
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = 512'd0;
        s_axis_tkeep = 64'd0;
        s_axis_tuser = 128'd0;
        s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        hist_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_m_valid", 512'(m_axis_tvalid), 512'(0));
        chk("rst_h_valid", 512'(hist_valid), 512'(0));
        chk("rst_err", 512'(err_count), 512'(0));
        chk("rst_m_data", m_axis_tdata, 512'(0));
        chk("rst_h_tuple", 512'(hist_tuple), 512'(0));
        chk("rst_s_ready", 512'(s_axis_tready), 512'(1));
        @(posedge clk);
        #1;

        // 1: ptr=3, 3-beat frame, everything ready.
        hist_log_n = 0;
        send_pkt(1, 4'd3, 3, 1'b1, acc0);
        wait_idle();
        chk("t1_hist_count", 512'(hist_log_n), 512'(8));
        chk("t1_first_entry", 512'(hist_log[0]), 512'(16'hA3));
        chk("t1_sixth_entry", 512'(hist_log[5]), 512'(16'hA0));
        chk("t1_last_entry", 512'(hist_log[7]), 512'(16'hA2));

        // 2: output ready toggles, tuple consumer stalled for 20 cycles.
        hist_log_n = 0;
        tog_en = 1'b1;
        hist_ready_at = cyc + 20;
        send_pkt(2, 4'd3, 3, 1'b0, acc0);
        wait_idle();
        tog_en = 1'b0;
        m_axis_tready = 1'b1;
        chk("t2_hist_count", 512'(hist_log_n), 512'(8));

        // 3: back-to-back packets, drain of the first held off until cycle +30.
        hist_ready_at = cyc + 30;
        send_pkt(3, 4'd5, 2, 1'b0, acc0);
        @(negedge clk);
        chk("t3_hdr0_stalled", 512'(s_axis_tready), 512'(0));
        send_pkt(4, 4'd1, 2, 1'b0, acc0);
        chk("t3_hdr0_after_drain", 512'(acc0 > last_hist_cyc), 512'(1));
        chk("t3_hdr0_after_ready", 512'(acc0 >= hist_ready_at), 512'(1));
        wait_idle();

        // 4: malformed 2-beat packet, then a good one.
        hist_log_n = 0;
        send_pkt(5, 4'd0, 0, 1'b0, acc0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_err_one", 512'(err_count), 512'(1));
        chk("t4_no_m", 512'(m_axis_tvalid), 512'(0));
        chk("t4_no_h", 512'(hist_valid), 512'(0));
        chk("t4_no_h_log", 512'(hist_log_n), 512'(0));
        send_pkt(6, 4'd2, 2, 1'b0, acc0);
        wait_idle();

        // 5: reset while payload beat 2 of 4 is presented.
        for (int j = 0; j < 8; j++) t[j] = mk_tuple(7, j);
        send_beat({48'h0, t[3], t[2], t[1], t[0], 16'h0000}, 64'h0, 128'h0, 1'b0, acc);
        send_beat({48'h0, t[7], t[6], t[5], t[4], 16'h0000}, 64'h0, 128'h0, 1'b0, acc);
        for (int k = 0; k < 8; k++) begin
            h_item_t e;
            e.t = t[k];
            e.idx = 3'(k);
            e.l = (k == 7);
            exp_h.push_back(e);
        end
        begin
            m_item_t e;
            e.d = beat_data(7, 0);
            e.k = beat_keep(0, 4);
            e.u = beat_user(7, 0);
            e.l = 1'b0;
            send_beat(e.d, e.k, e.u, e.l, acc);
            exp_m.push_back(e);
        end
        s_axis_tdata = beat_data(7, 1);
        s_axis_tvalid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        exp_m.delete();
        exp_h.delete();
        err_exp = 0;
        chk("t5_m_valid_cleared", 512'(m_axis_tvalid), 512'(0));
        chk("t5_h_valid_cleared", 512'(hist_valid), 512'(0));
        chk("t5_err_cleared", 512'(err_count), 512'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_pkt(8, 4'd6, 2, 1'b0, acc0);
        wait_idle();

        // 6: out-of-range pointer uses its low bits.
        hist_log_n = 0;
        send_pkt(9, 4'hF, 1, 1'b0, acc0);
        wait_idle();
        chk("t6_first_entry", 512'(hist_log[0]), 512'(16'hA7));
        chk("t6_last_entry", 512'(hist_log[7]), 512'(16'hA6));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_history_extract.md
Name: packet_history_extract

Overview:
- Receive end of the packet-history stream: each packet on the AXI-Stream input carries two prepended 512-bit history header beats ahead of the original frame.
- Strips the two header beats and forwards the original frame unchanged on the master stream.
- Drains the carried tuple history, oldest first, on a side tuple interface.
- Sits at the capture/host end of the datapath, ahead of statistics or DMA logic.

Parameters:
- C_M_AXIS_DATA_WIDTH, 512, master tdata width (tkeep = width/8).
- C_S_AXIS_DATA_WIDTH, 512, slave tdata width; must equal master width.
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width.
- TUPLE_WIDTH, 112, tuple width: src IP 32, dst IP 32, src L4 port 16, dst L4 port 16, length 16.
- HIST_ENTRIES, 8, tuples per packet; 4 per header beat.
- PTR_WIDTH, 4, width of the write-pointer field in header beat 0.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  512  input stream data.
- s_axis_tkeep  in  64  input byte enables.
- s_axis_tuser  in  128  input sideband.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of packet.
- m_axis_tdata  out  512  stripped frame data.
- m_axis_tkeep  out  64  stripped frame byte enables.
- m_axis_tuser  out  128  stripped frame sideband.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of packet.
- hist_tuple  out  112  drained history tuple.
- hist_index  out  3  age order of the tuple: 0 = oldest.
- hist_valid  out  1  tuple valid.
- hist_ready  in  1  tuple consumer ready.
- hist_last  out  1  asserted with index HIST_ENTRIES-1.
- err_count  out  16  malformed-header counter, saturating.

Behaviour:
- Header layout:
  - Beat 0: ptr in [PTR_WIDTH-1:0]; bits [15:PTR_WIDTH] ignored; tuple k (k=0..3) at [16+112k +: 112]; bits [511:464] ignored.
  - Beat 1: tuple 4+k at the same offsets.
  - Header-beat tkeep and tuser are ignored.
- Reset: state=HDR0, all valids 0, err_count 0, drain idle, m_axis_* and hist_* data outputs 0.
- Input FSM states: HDR0, HDR1, PAYLOAD.
- HDR0:
  - s_axis_tready = !drain_busy.
  - On a handshake: latch ptr and tuples 0..3.
  - If tlast=1: err_count+1 (saturating), discard, stay in HDR0.
  - Else go to HDR1.
- HDR1:
  - s_axis_tready = 1.
  - On a handshake: latch tuples 4..7.
  - If tlast=1: err_count+1, discard the whole packet, no drain, back to HDR0.
  - Else set drain_busy and go to PAYLOAD.
- PAYLOAD:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready (single register stage).
  - Beats are copied verbatim: tdata, tkeep, tuser, tlast.
  - The beat with tlast → HDR0.
  - Latency is 1 cycle from input handshake to m_axis_tvalid.
- Output register: holds its value while m_axis_tvalid && !m_axis_tready. No bubbles when tready is held high.
- Drain:
  - Runs while drain_busy.
  - Output k is entry (ptr + k) mod HIST_ENTRIES, with hist_index=k.
  - Advances on hist_valid && hist_ready.
  - drain_busy clears on the handshake with hist_last.
  - Drain and payload run concurrently.
  - The next packet's HDR0 stalls until the drain completes.
- hist_valid and hist_tuple are registered and stable until accepted.
- ptr values ≥ HIST_ENTRIES use the low 3 bits.
- Reset mid-packet or mid-drain: everything is aborted immediately; the partial packet is never output.
- Zero-length payload (tlast on header beat 1) counts as malformed.

Test Plan:
- Header with ptr=3, tuple j = {16'hA0+j, ...}, then a 3-beat frame, tready=1:
  - m output is the 3 beats, byte-identical, first beat 1 cycle after acceptance, tlast on beat 3.
  - hist outputs entries 3,4,5,6,7,0,1,2 with index 0..7 and hist_last on index 7.
- Same packet with m_axis_tready toggling 1010 and hist_ready=0 for 20 cycles:
  - No frame beat lost or duplicated; data held stable under stall.
  - Tuples held until hist_ready rises.
- Two back-to-back packets, hist_ready=0 until cycle 30:
  - s_axis_tready=0 at packet 2 HDR0 until drain 1 completes.
  - Packet 2's history then correct.
- Malformed 2-beat packet (tlast on beat 1):
  - err_count=1, no m output, no hist output.
  - The next well-formed packet is handled correctly.
- Reset asserted during payload beat 2 of 4:
  - All valids 0 the next cycle, err_count=0.
  - A subsequent packet is processed cleanly.
- ptr=4'hF: drain starts at entry 7.
